wb_config_loader: RTL and testbench

Wishbone slave that converts 32-bit configuration words from the management SoC into per-column serial bit streams for the fabric's configuration chains. It drives one region's `cen`, `set_out[3:0]` and `shift_out[3:0]`, which feed the bottom tile of each column. The region's four column chains are then clocked tile-to-tile up the column. Each configuration region has one instance; the top level ORs `wbs_ack_o`/`wbs_data_o` across instances.

---
 rtl/wb_config_loader_if.sv | 22 ++
 rtl/wb_config_loader.sv | 128 ++++++++++++
 tb/tb_wb_config_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_config_loader_if.sv
// Wishbone classic slave bus bundle for the configuration loader.
// The master drives strobes, address and write data; the slave returns ack and read data.
interface wb_config_loader_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_addr_i;
  logic [31:0] wbs_data_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_data_i,
    output wbs_ack_o, wbs_data_o
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_addr_i, wbs_data_i,
    input  wbs_ack_o, wbs_data_o
  );
endinterface

// File: rtl/wb_config_loader.sv
// Wishbone slave that serialises 32-bit configuration words into per-column chain bits
// and issues a region-wide latch strobe on COMMIT.
module wb_config_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned COLS      = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_config_loader_if.slave      wb,
  output logic                   cen,
  output logic [COLS-1:0]        shift_out,
  output logic [COLS-1:0]        set_out
);

  localparam int unsigned STEPS = 32 / COLS;
  localparam int unsigned IDX_W = $clog2(STEPS);
  localparam logic [1:0]  OFF_DATA   = 2'd0;
  localparam logic [1:0]  OFF_COMMIT = 2'd1;
  localparam logic [1:0]  OFF_STATUS = 2'd2;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ack_d;
  logic [31:0]       rdata_d;
  logic              cen_d;
  logic [COLS-1:0]   shift_d;
  logic [COLS-1:0]   set_d;

  logic              hit_c;
  logic [1:0]        off_c;
  logic              busy_c;
  logic              unused_addr_c;

  assign hit_c  = wb.wbs_cyc_i & wb.wbs_stb_i & ~wb.wbs_ack_o &
                  (wb.wbs_addr_i[31:4] == BASE_ADDR[31:4]);
  assign off_c  = wb.wbs_addr_i[3:2];
  assign busy_c = (state_q != IDLE);
  assign unused_addr_c = ^wb.wbs_addr_i[1:0];

  // Next-state, bus response and chain outputs
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    rdata_d = 32'h0;

    if (hit_c) begin
      unique case (off_c)
        OFF_DATA, OFF_COMMIT: begin
          // Writes that would start chain activity wait for IDLE; reads never stall
          if (!wb.wbs_we_i) begin
            ack_d = 1'b1;
          end else if (state_q == IDLE) begin
            ack_d = 1'b1;
            if (off_c == OFF_COMMIT) begin
              state_d = COMMIT;
              cnt_d   = 16'h0;
            end else if (wb.wbs_sel_i == 4'hF) begin
              state_d = SHIFT;
              word_d  = wb.wbs_data_i;
              idx_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        OFF_STATUS: begin
          ack_d = 1'b1;
          if (!wb.wbs_we_i) rdata_d = {busy_c, err_q, 14'b0, cnt_q};
        end
        default: ack_d = 1'b1;
      endcase
    end

    unique case (state_q)
      SHIFT: begin
        if (idx_q == IDX_W'(STEPS - 1)) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          word_d = word_q >> COLS;
        end
      end
      COMMIT:  state_d = IDLE;
      default: ;
    endcase

    cen_d   = (state_d == SHIFT);
    shift_d = cen_d ? word_d[COLS-1:0] : '0;
    set_d   = (state_d == COMMIT) ? '1 : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      word_q        <= 32'h0;
      idx_q         <= '0;
      cnt_q         <= 16'h0;
      err_q         <= 1'b0;
      wb.wbs_ack_o  <= 1'b0;
      wb.wbs_data_o <= 32'h0;
      cen           <= 1'b0;
      shift_out     <= '0;
      set_out       <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_q         <= err_d;
      wb.wbs_ack_o  <= ack_d;
      wb.wbs_data_o <= rdata_d;
      cen           <= cen_d;
      shift_out     <= shift_d;
      set_out       <= set_d;
    end
  end

endmodule

// File: tb/tb_wb_config_loader.sv
// Randomised scoreboard bench for wb_config_loader: stimulus pushes expected acks,
// nibbles and latch strobes; a negedge monitor pops and compares them.
module tb_wb_config_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen;
  logic [3:0] shift_out;
  logic [3:0] set_out;

  always #5 clk = ~clk;

  wb_config_loader_if bus ();

  wb_config_loader #(.BASE_ADDR(BASE), .COLS(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .cen      (cen),
    .shift_out(shift_out),
    .set_out  (set_out)
  );

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] ack_q[$];
  logic [3:0]  sh_q[$];
  int          set_pending = 0;
  logic [15:0] m_cnt = 16'h0;
  logic        m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event observed or bound expired with nothing expected", name);
  endtask

  function automatic logic [31:0] exp_status(input logic busy, input logic [15:0] cnt);
    return {busy, m_err, 14'b0, cnt};
  endfunction

  // Monitor: every DUT output event is matched against the scoreboard queues
  always @(negedge clk) begin
    if (bus.wbs_ack_o === 1'b1) begin
      if (ack_q.size() == 0) fail_now("unexpected_ack");
      else check("rdata", bus.wbs_data_o, ack_q.pop_front());
    end else begin
      check("rdata_zero_without_ack", bus.wbs_data_o, 32'h0);
    end
    if (cen === 1'b1) begin
      if (sh_q.size() == 0) fail_now("unexpected_cen");
      else check("shift_out", 32'(shift_out), 32'(sh_q.pop_front()));
    end else begin
      check("shift_zero_without_cen", 32'(shift_out), 32'h0);
    end
    if (set_out !== 4'h0) begin
      if (set_pending == 0) fail_now("unexpected_set_out");
      else begin
        set_pending--;
        check("set_out_value", 32'(set_out), 32'hF);
        check("cen_low_in_commit", 32'(cen), 32'h0);
      end
    end
  end

  task automatic wb_issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, output int lat,
                          output logic cen_at_ack, output logic [3:0] set_at_ack);
    bus.wbs_cyc_i  = 1'b1;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = we;
    bus.wbs_sel_i  = sel;
    bus.wbs_addr_i = addr;
    bus.wbs_data_i = wdata;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.wbs_ack_o !== 1'b1 && lat < 40);
    if (bus.wbs_ack_o !== 1'b1) fail_now("ack_timeout");
    cen_at_ack = cen;
    set_at_ack = set_out;
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic data_write(input logic [31:0] w, input logic [3:0] sel,
                            output int lat, output logic cen_at_ack);
    logic [3:0] s;
    ack_q.push_back(32'h0);
    if (sel == 4'hF) begin
      for (int i = 0; i < 8; i++) sh_q.push_back(w[4*i +: 4]);
      m_cnt = m_cnt + 16'd1;
    end else begin
      m_err = 1'b1;
    end
    wb_issue(1'b1, BASE, sel, w, lat, cen_at_ack, s);
  endtask

  task automatic commit_write(output logic [3:0] set_at_ack);
    int l;
    logic c;
    ack_q.push_back(32'h0);
    set_pending++;
    m_cnt = 16'h0;
    wb_issue(1'b1, BASE + 32'h4, 4'hF, 32'h0, l, c, set_at_ack);
  endtask

  task automatic status_read(input logic [31:0] exp);
    int l;
    logic c;
    logic [3:0] s;
    ack_q.push_back(exp);
    wb_issue(1'b0, BASE + 32'h8, 4'hF, 32'h0, l, c, s);
  endtask

  task automatic drain();
    int n = 0;
    while ((sh_q.size() != 0 || set_pending != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sh_q.size() != 0 || set_pending != 0) fail_now("drain_timeout");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    int         n;
    logic       c;
    logic [3:0] s;
    logic [15:0] cnt_before;

    bus.wbs_cyc_i  = 1'b0;
    bus.wbs_stb_i  = 1'b0;
    bus.wbs_we_i   = 1'b0;
    bus.wbs_sel_i  = 4'h0;
    bus.wbs_addr_i = 32'h0;
    bus.wbs_data_i = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Quiet after reset
    repeat (5) begin
      @(negedge clk);
      check("reset_ack", 32'(bus.wbs_ack_o), 32'h0);
      check("reset_cen", 32'(cen), 32'h0);
      check("reset_set", 32'(set_out), 32'h0);
    end
    @(posedge clk);
    #1;
    status_read(32'h0);

    // Single word, latency and nibble order
    data_write(32'h8765_4321, 4'hF, lat, c);
    check("data_ack_latency", 32'(lat), 32'd2);
    check("cen_with_ack", 32'(c), 32'h1);
    drain();
    @(negedge clk);
    check("cen_low_after_word", 32'(cen), 32'h0);
    @(posedge clk);
    #1;
    status_read(32'h0000_0001);

    // Back-to-back words stall until IDLE
    data_write($urandom, 4'hF, lat, c);
    data_write($urandom, 4'hF, lat, c);
    check("b2b_ack_latency", 32'(lat), 32'd9);
    drain();
    status_read(exp_status(1'b0, m_cnt));

    // STATUS while shifting reports busy with the old count
    cnt_before = m_cnt;
    data_write(32'hA5A5_0F0F, 4'hF, lat, c);
    status_read(exp_status(1'b1, cnt_before));
    drain();

    // COMMIT strobe
    commit_write(s);
    check("set_with_ack", 32'(s), 32'hF);
    @(negedge clk);
    check("set_one_cycle", 32'(set_out), 32'h0);
    @(posedge clk);
    #1;
    status_read(32'h0);

    // Partial byte enables raise err and shift nothing
    data_write(32'hDEAD_BEEF, 4'h3, lat, c);
    check("partial_sel_no_cen", 32'(c), 32'h0);
    status_read(32'h4000_0000);

    // Out-of-window address is never acked
    bus.wbs_cyc_i  = 1'b1;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_we_i   = 1'b1;
    bus.wbs_sel_i  = 4'hF;
    bus.wbs_addr_i = BASE + 32'h10;
    bus.wbs_data_i = 32'h1234_5678;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.wbs_ack_o === 1'b1) n++;
    end
    check("miss_ack_count", 32'(n), 32'h0);
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;

    // Reserved and data-register reads return zero
    ack_q.push_back(32'h0);
    wb_issue(1'b0, BASE + 32'hC, 4'hF, 32'h0, lat, c, s);
    ack_q.push_back(32'h0);
    wb_issue(1'b0, BASE, 4'hF, 32'h0, lat, c, s);

    // Held strobe: ack drops for one cycle, then the access repeats
    ack_q.push_back(exp_status(1'b0, m_cnt));
    ack_q.push_back(exp_status(1'b0, m_cnt));
    bus.wbs_cyc_i  = 1'b1;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_addr_i = BASE + 32'h8;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.wbs_ack_o !== 1'b1 && n < 20);
    @(negedge clk);
    check("ack_low_with_stb_held", 32'(bus.wbs_ack_o), 32'h0);
    @(posedge clk);
    #1;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during the 4th shift cycle aborts the word
    data_write(32'hFEDC_BA98, 4'hF, lat, c);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    sh_q.delete();
    m_cnt = 16'h0;
    m_err = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
    check("abort_cen", 32'(cen), 32'h0);
    check("abort_shift", 32'(shift_out), 32'h0);
    @(posedge clk);
    #1;
    status_read(32'h0);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        logic [3:0] sel;
        sel = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        data_write($urandom, sel, lat, c);
      end else if (op == 5) begin
        commit_write(s);
      end else if (op <= 7) begin
        drain();
        status_read(exp_status(1'b0, m_cnt));
      end else if (op == 8) begin
        ack_q.push_back(32'h0);
        wb_issue(1'($urandom_range(0, 1)), BASE + 32'hC + 32'($urandom_range(0, 3)),
                 4'hF, $urandom, lat, c, s);
      end else begin
        ack_q.push_back(32'h0);
        wb_issue(1'b0, BASE + 32'(4 * $urandom_range(0, 1)), 4'hF, 32'h0, lat, c, s);
      end
    end
    drain();
    status_read(exp_status(1'b0, m_cnt));
    repeat (3) @(posedge clk);
    #1;

    check("ack_queue_empty", 32'(ack_q.size()), 32'h0);
    check("shift_queue_empty", 32'(sh_q.size()), 32'h0);
    check("set_queue_empty", 32'(set_pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
